fusion_acc_ctrl: RTL and testbench
==================================

# fusion_acc_ctrl

Sequencing controller for the Fusion Unit accumulator. It accepts a job of N partial sums from the 4x4 PE array, clears the accumulator, and feeds exactly N valid PE sums into it, gating idle cycles to zero. It then captures the 28-bit total and presents it downstream on a valid/ready handshake. It sits between the PE array output and the accumulator, and owns the accumulator's reset and input.

## Interface
- LEN_W, 8, width of the job-length field (max N = 2^LEN_W − 1)
- SUM_W, 20, PE partial-sum width
- ACC_W, 28, accumulator width
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  input  1  job request; sampled only in IDLE
- num_terms  input  LEN_W  number of partial sums N; latched when start is accepted
- busy  output  1  high in every state except IDLE
- pe_valid  input  1  pe_sum_in carries a partial sum this cycle
- pe_ready  output  1  controller accepts a sum this cycle (high only in ACCUM)
- pe_sum_in  input  SUM_W  signed partial sum from the PE array
- acc_reset  output  1  drives the accumulator's reset; equals reset OR (state==CLEAR), combinational
- acc_pe_sum  output  SUM_W  drives the accumulator's PE_sum input; equals pe_sum_in when (ACCUM and pe_valid), otherwise 0; combinational
- acc_total  input  ACC_W  accumulator's total_output
- out_valid  output  1  out_data holds a finished result
- out_ready  input  1  downstream accepts the result
- out_data  output  ACC_W  registered final total

## Operation
- The FSM has five states: IDLE, CLEAR, ACCUM, DRAIN, HOLD. Reset forces IDLE.
- IDLE:
  - If start is high: latch num_terms into len_r, clear term counter cnt, go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR: acc_reset=1 for exactly one cycle, so the accumulator reads 0 on the next cycle.
  - If len_r==0, go to DRAIN.
  - Otherwise go to ACCUM.
- ACCUM: pe_ready=1.
  - Each cycle with pe_valid=1 is one accepted term; cnt increments.
  - When pe_valid=0, acc_pe_sum=0, so the accumulator holds its value; no term is counted.
  - When a term is accepted and cnt==len_r−1, go to DRAIN.
- DRAIN: acc_total now holds the final sum. Register out_data<=acc_total, then go to HOLD.
- HOLD: out_valid=1 and out_data stays stable.
  - If out_ready=1, return to IDLE; out_valid is 0 from the next cycle.
  - While out_ready=0, stay in HOLD with acc_pe_sum=0.
- Arithmetic: sign extension and addition happen inside the accumulator. The total wraps modulo 2^ACC_W; the controller performs no saturation or overflow flagging.
- start while busy is ignored and is not queued.
- In IDLE, CLEAR, DRAIN and HOLD, acc_pe_sum=0 and pe_ready=0.

## Timing
- Reset values of registered outputs: out_valid=0, out_data=0, busy=0, pe_ready=0, cnt=0.
- Reset values of combinational outputs: acc_reset=1 while reset is high; acc_pe_sum=0.
- Cycle numbering: start is sampled at edge 0; cycle 1 is CLEAR; ACCUM begins in cycle 2.
  - With N terms and no bubbles, the last term is presented in cycle N+1.
  - DRAIN is cycle N+2; out_valid first rises in cycle N+3.
  - Bubbles add one cycle each.
- N=0: CLEAR in cycle 1, DRAIN in cycle 2, out_valid in cycle 3 with out_data=0.
- Handshake: the transfer completes on the edge where out_valid and out_ready are both high. A new start is accepted at the earliest one cycle after that edge, once back in IDLE.
- Reset mid-job (any state): next cycle is IDLE with out_valid=0, and the accumulator is cleared because acc_reset follows reset. No partial result is emitted.
- Simultaneous start and reset: reset wins.

## Test plan
- N=4, sums 1,2,3,4 back-to-back, out_ready=1 -> out_valid in cycle 7 with out_data=10; busy falls in cycle 8.
- N=2, sums 0xFFFFB (−5) and 3 -> out_data=0xFFFFFFE (−2).
- N=3 with pe_valid pattern 1,0,0,1,0,1 (sums 7,x,x,8,x,9) -> out_data=24; bubble data is ignored; out_valid 3 cycles later than the no-bubble case.
- Result ready with out_ready low for 3 cycles -> out_valid and out_data held constant; no change after release; start pulses during HOLD are ignored.
- num_terms=0 -> out_data=0 at cycle 3; pe_ready never asserts.
- Reset asserted in the second ACCUM cycle of an N=5 job, then a new N=1 job with sum 6 -> out_data=6 (no residue from the aborted job).

Source files
------------

// File: rtl/fusion_acc_ctrl.sv
// ---------------------------------------------------------------------------
// fusion_acc_ctrl
//
// Sequencing controller for the Fusion Unit accumulator. A job of N partial
// sums is accepted on start. The controller clears the accumulator for one
// cycle and then feeds exactly N valid PE sums into it. Idle cycles are gated
// to zero. It then captures the accumulator total and offers it downstream on
// a valid/ready handshake.
//
// Ports
//   clk, reset    clock; synchronous active-high reset
//   start         job request, only looked at in IDLE
//   num_terms     job length N, latched when start is accepted
//   busy          high in every state except IDLE
//   pe_valid      PE array presents a partial sum this cycle
//   pe_ready      controller accepts a sum this cycle (ACCUM only)
//   pe_sum_in     signed partial sum from the PE array
//   acc_reset     accumulator reset (reset OR CLEAR), combinational
//   acc_pe_sum    accumulator input; the PE sum when a term is accepted, else 0
//   acc_total     accumulator running total
//   out_valid     out_data holds a finished result
//   out_ready     downstream accepts the result
//   out_data      registered final total
// ---------------------------------------------------------------------------
module fusion_acc_ctrl #(
    parameter int LEN_W = 8,
    parameter int SUM_W = 20,
    parameter int ACC_W = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] num_terms,
    output logic             busy,
    input  logic             pe_valid,
    output logic             pe_ready,
    input  logic [SUM_W-1:0] pe_sum_in,
    output logic             acc_reset,
    output logic [SUM_W-1:0] acc_pe_sum,
    input  logic [ACC_W-1:0] acc_total,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [LEN_W-1:0] LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] out_data_r;
    logic             term_acc;
    logic             last_term;

    // A term is consumed only in ACCUM on a valid cycle; bubbles cost nothing.
    assign term_acc  = (state == S_ACCUM) && pe_valid;
    // len_r is never 0 in ACCUM (CLEAR skips straight to DRAIN), so
    // len_r-1 cannot underflow here.
    assign last_term = term_acc && (cnt == (len_r - LEN_ONE));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CLEAR;
            S_CLEAR: state_nx = (len_r == LEN_ZERO) ? S_DRAIN : S_ACCUM;
            S_ACCUM: if (last_term) state_nx = S_DRAIN;
            // Accumulator has absorbed the last term by now; capture it.
            S_DRAIN: state_nx = S_HOLD;
            S_HOLD:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            len_r      <= '0;
            cnt        <= '0;
            out_data_r <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_r <= num_terms;
                        cnt   <= '0;
                    end
                end
                S_ACCUM: begin
                    if (term_acc) cnt <= cnt + LEN_ONE;
                end
                S_DRAIN: begin
                    out_data_r <= acc_total;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode directly from the state register, so none of them has
    // a combinational path from an input except the accumulator feed.
    assign busy       = (state != S_IDLE);
    assign pe_ready   = (state == S_ACCUM);
    assign out_valid  = (state == S_HOLD);
    assign out_data   = out_data_r;

    // Reset mid-job must also wipe the accumulator, so it follows reset.
    assign acc_reset  = reset || (state == S_CLEAR);
    assign acc_pe_sum = term_acc ? pe_sum_in : '0;

endmodule

// File: tb/tb_fusion_acc_ctrl.sv
module tb_fusion_acc_ctrl;
    localparam int LEN_W = 8;
    localparam int SUM_W = 20;
    localparam int ACC_W = 28;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] num_terms;
    logic             busy;
    logic             pe_valid;
    logic             pe_ready;
    logic [SUM_W-1:0] pe_sum_in;
    logic             acc_reset;
    logic [SUM_W-1:0] acc_pe_sum;
    logic [ACC_W-1:0] acc_total;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;

    fusion_acc_ctrl #(.LEN_W(LEN_W), .SUM_W(SUM_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .start(start), .num_terms(num_terms),
        .busy(busy), .pe_valid(pe_valid), .pe_ready(pe_ready),
        .pe_sum_in(pe_sum_in), .acc_reset(acc_reset), .acc_pe_sum(acc_pe_sum),
        .acc_total(acc_total), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Accumulator the controller drives: sign-extend and add, wrap mod 2^28.
    logic [ACC_W-1:0] acc = '0;
    always @(posedge clk) begin
        if (acc_reset) acc <= '0;
        else           acc <= acc + {{(ACC_W-SUM_W){acc_pe_sum[SUM_W-1]}}, acc_pe_sum};
    end
    assign acc_total = acc;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int failures = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic             pat_v[16];
    logic [SUM_W-1:0] pat_s[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is positioned at a negedge in IDLE. Pattern entries are presented
    // one per ACCUM cycle; hold_cyc>0 keeps out_ready low that many cycles.
    task automatic run_job(input int n, input int plen, input int hold_cyc, input string tag);
        logic [ACC_W-1:0] e;
        logic [ACC_W-1:0] held;
        logic [ACC_W-1:0] want;
        int c0;
        int k;
        e = '0;
        for (int i = 0; i < plen; i++)
            if (pat_v[i]) e = e + {{(ACC_W-SUM_W){pat_s[i][SUM_W-1]}}, pat_s[i]};
        exp_q.push_back(e);
        out_ready = (hold_cyc == 0);
        start = 1'b1;
        num_terms = n[LEN_W-1:0];
        @(negedge clk);                      // cycle 1: CLEAR
        c0 = edge_cnt;
        start = 1'b0;
        chk({tag, "_clr_busy"}, 32'(busy), 32'd1);
        chk({tag, "_clr_accrst"}, 32'(acc_reset), 32'd1);
        chk({tag, "_clr_peready"}, 32'(pe_ready), 32'd0);
        for (int i = 0; i < plen; i++) begin
            @(negedge clk);
            pe_valid = pat_v[i];
            pe_sum_in = pat_s[i];
            #1;
            chk({tag, "_acc_peready"}, 32'(pe_ready), 32'd1);
            chk({tag, "_acc_gate"}, 32'(acc_pe_sum), pat_v[i] ? 32'(pat_s[i]) : 32'd0);
        end
        @(negedge clk);                      // DRAIN: valid with junk must be gated
        pe_valid = 1'b1;
        pe_sum_in = 20'h5A5A5;
        #1;
        chk({tag, "_drain_gate"}, 32'(acc_pe_sum), 32'd0);
        chk({tag, "_drain_peready"}, 32'(pe_ready), 32'd0);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            pe_valid = 1'b0;
            k++;
            if (out_valid) break;
        end
        chk({tag, "_valid_cycle"}, 32'(edge_cnt - c0 + 1), 32'(plen + 3));
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_data"}, 32'(out_data), 32'(want));
        held = out_data;
        for (int h = 0; h < hold_cyc; h++) begin
            if (h == 1) start = 1'b1;        // ignored while busy
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(out_data), 32'(held));
            @(negedge clk);
            start = 1'b0;
        end
        if (hold_cyc > 0) begin
            chk({tag, "_rel_valid"}, 32'(out_valid), 32'd1);
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_done_data"}, 32'(out_data), 32'(held));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_terms = '0; pe_valid = 1'b0;
        pe_sum_in = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_peready", 32'(pe_ready), 32'd0);
        chk("rst_accrst", 32'(acc_reset), 32'd1);
        chk("rst_accsum", 32'(acc_pe_sum), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_accrst", 32'(acc_reset), 32'd0);

        // N=4, 1..4 back to back -> 10, out_valid cycle 7, busy low cycle 8
        for (int i = 0; i < 4; i++) begin pat_v[i] = 1'b1; pat_s[i] = SUM_W'(i + 1); end
        run_job(4, 4, 0, "n4");

        // N=2, -5 + 3 -> -2 in 28 bits
        pat_v[0] = 1'b1; pat_s[0] = 20'hFFFFB;
        pat_v[1] = 1'b1; pat_s[1] = 20'h00003;
        run_job(2, 2, 0, "neg");

        // N=3 with bubbles carrying junk data -> 24, three cycles later
        pat_v[0] = 1'b1; pat_s[0] = 20'd7;
        pat_v[1] = 1'b0; pat_s[1] = 20'h12345;
        pat_v[2] = 1'b0; pat_s[2] = 20'hFFFFF;
        pat_v[3] = 1'b1; pat_s[3] = 20'd8;
        pat_v[4] = 1'b0; pat_s[4] = 20'h0ABCD;
        pat_v[5] = 1'b1; pat_s[5] = 20'd9;
        run_job(3, 6, 0, "bub");

        // backpressure: out_ready low 3 cycles, start pulse during HOLD
        pat_v[0] = 1'b1; pat_s[0] = 20'h7FFFF;
        pat_v[1] = 1'b1; pat_s[1] = 20'h7FFFF;
        run_job(2, 2, 3, "hold");

        // N=0: result 0 in cycle 3, no ACCUM at all
        run_job(0, 0, 0, "n0");

        // reset during second ACCUM cycle of an N=5 job
        start = 1'b1; num_terms = 8'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        pe_valid = 1'b1; pe_sum_in = 20'd100;
        @(negedge clk);
        pe_sum_in = 20'd200; reset = 1'b1;
        #1;
        chk("abort_accrst", 32'(acc_reset), 32'd1);
        @(negedge clk);
        reset = 1'b0; pe_valid = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_accrst_off", 32'(acc_reset), 32'd0);
        @(negedge clk);
        pat_v[0] = 1'b1; pat_s[0] = 20'd6;
        run_job(1, 1, 0, "after_abort");

        // start together with reset: reset wins
        start = 1'b1; num_terms = 8'd3; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        chk("start_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("start_rst_busy2", 32'(busy), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
